// File: rtl/puf_challenge_sequencer.sv
// -----------------------------------------------------------------------------
// puf_challenge_sequencer
//
// Drives repeated evaluations of one challenge on an arbiter PUF and
// majority-votes the sampled responses. Each evaluation clears the arbiter,
// launches the race edge, waits for the arbiter to settle, then samples the
// synchronized response. After VOTES evaluations the result is held until the
// consumer acknowledges it.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for start; ch_out keeps its last value
//   CLEAR  | arbiter / feed-forward flops held in reset (puf_clr=1)
//   LAUNCH | race edge asserted (puf_launch 0->1), one cycle
//   SETTLE | race propagating; wait SETTLE_CYC cycles
//   SAMPLE | fold synchronized response into ones_count, one cycle
//   DONE   | result presented with resp_valid until resp_ack
//
// Ports:
//   clk_i          clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   start_i        request an evaluation of challenge_i (accepted in IDLE)
//   challenge_i    challenge, latched on accept
//   resp_ack_i     consumer acknowledge, honoured only in DONE
//   puf_resp_i     asynchronous arbiter output
//   ch_out_o       PUF challenge bus
//   puf_launch_o   PUF race edge
//   puf_clr_o      active-high arbiter reset
//   busy_o         high whenever the sequencer is not in IDLE
//   resp_valid_o   result valid (DONE)
//   resp_bit_o     majority response bit
//   unstable_o     evaluations disagreed
//   ones_count_o   number of evaluations that sampled 1
// -----------------------------------------------------------------------------
module puf_challenge_sequencer #(
    parameter int CH_W       = 8,
    parameter int VOTES      = 7,   // odd, >= 1
    parameter int CLR_CYC    = 4,   // >= 1
    parameter int SETTLE_CYC = 16,  // >= 3
    localparam int CNT_W     = $clog2(VOTES + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [CH_W-1:0]  challenge_i,
    input  logic             resp_ack_i,
    input  logic             puf_resp_i,
    output logic [CH_W-1:0]  ch_out_o,
    output logic             puf_launch_o,
    output logic             puf_clr_o,
    output logic             busy_o,
    output logic             resp_valid_o,
    output logic             resp_bit_o,
    output logic             unstable_o,
    output logic [CNT_W-1:0] ones_count_o
);

    localparam int IDX_W   = (VOTES > 1) ? $clog2(VOTES) : 1;
    localparam int TMR_MAX = (CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] CLR_LOAD    = TMR_W'(CLR_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_VOTE   = IDX_W'(VOTES - 1);
    localparam logic [CNT_W-1:0] HALF_VOTES  = CNT_W'(VOTES / 2);
    localparam logic [CNT_W-1:0] ALL_VOTES   = CNT_W'(VOTES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LAUNCH = 3'd2,
        SETTLE = 3'd3,
        SAMPLE = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        sync_q;
    logic [IDX_W-1:0]  vote_q, vote_d;
    logic [CNT_W-1:0]  ones_q, ones_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [CH_W-1:0]   ch_q, ch_d;

    // Two-flop synchronizer for the arbiter output; sync_q[1] is the only
    // copy of the response that the control logic looks at.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], puf_resp_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            vote_q  <= '0;
            ones_q  <= '0;
            tmr_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            vote_q  <= vote_d;
            ones_q  <= ones_d;
            tmr_q   <= tmr_d;
            ch_q    <= ch_d;
        end
    end

    // Next-state logic. The phase timer is a down-counter loaded with
    // (length - 1) on entry to CLEAR/SETTLE, so the phase ends on the cycle
    // it reads zero.
    always_comb begin
        state_d = state_q;
        vote_d  = vote_q;
        ones_d  = ones_q;
        tmr_d   = tmr_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    ch_d    = challenge_i;
                    vote_d  = '0;
                    ones_d  = '0;
                    tmr_d   = CLR_LOAD;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (tmr_q == '0) begin
                    state_d = LAUNCH;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            LAUNCH: begin
                tmr_d   = SETTLE_LOAD;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (tmr_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            SAMPLE: begin
                // At most VOTES increments, and CNT_W holds VOTES, so no wrap.
                ones_d = ones_q + CNT_W'(sync_q[1]);
                if (vote_q == LAST_VOTE) begin
                    state_d = DONE;
                end else begin
                    vote_d  = vote_q + IDX_W'(1);
                    tmr_d   = CLR_LOAD;
                    state_d = CLEAR;
                end
            end
            DONE: begin
                // Any start arriving with the ack is dropped: we only leave
                // for IDLE here, and IDLE looks at start on the next cycle.
                if (resp_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the registered state so they all drop in the
    // same instant that the asynchronous reset clears state_q.
    always_comb begin
        puf_clr_o    = 1'b0;
        puf_launch_o = 1'b0;
        resp_valid_o = 1'b0;
        resp_bit_o   = 1'b0;
        unstable_o   = 1'b0;
        busy_o       = (state_q != IDLE);
        case (state_q)
            CLEAR: begin
                puf_clr_o = 1'b1;
            end
            LAUNCH, SETTLE, SAMPLE: begin
                puf_launch_o = 1'b1;
            end
            DONE: begin
                resp_valid_o = 1'b1;
                resp_bit_o   = (ones_q > HALF_VOTES);
                unstable_o   = (ones_q != '0) && (ones_q != ALL_VOTES);
            end
            default: begin
            end
        endcase
    end

    assign ch_out_o     = ch_q;
    assign ones_count_o = ones_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
module tb_puf_challenge_sequencer;

    localparam int CH_W       = 8;
    localparam int VOTES      = 7;
    localparam int CLR_CYC    = 4;
    localparam int SETTLE_CYC = 16;
    localparam int CNT_W      = $clog2(VOTES + 1);
    localparam int VOTE_LEN   = CLR_CYC + SETTLE_CYC + 2;
    // resp_valid appears in cycle k+1+VOTES*VOTE_LEN, i.e. after this many
    // further edges following the accepting edge k.
    localparam int LATENCY    = VOTES * VOTE_LEN;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CH_W-1:0]  challenge;
    logic             resp_ack;
    logic             puf_resp;
    logic [CH_W-1:0]  ch_out;
    logic             puf_launch;
    logic             puf_clr;
    logic             busy;
    logic             resp_valid;
    logic             resp_bit;
    logic             unstable;
    logic [CNT_W-1:0] ones_count;

    int tests = 0;
    int fails = 0;

    puf_challenge_sequencer #(
        .CH_W       (CH_W),
        .VOTES      (VOTES),
        .CLR_CYC    (CLR_CYC),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .challenge_i  (challenge),
        .resp_ack_i   (resp_ack),
        .puf_resp_i   (puf_resp),
        .ch_out_o     (ch_out),
        .puf_launch_o (puf_launch),
        .puf_clr_o    (puf_clr),
        .busy_o       (busy),
        .resp_valid_o (resp_valid),
        .resp_bit_o   (resp_bit),
        .unstable_o   (unstable),
        .ones_count_o (ones_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ch_out"},     32'(ch_out),     0);
        check({tag, "_launch"},     32'(puf_launch), 0);
        check({tag, "_clr"},        32'(puf_clr),    0);
        check({tag, "_busy"},       32'(busy),       0);
        check({tag, "_valid"},      32'(resp_valid), 0);
        check({tag, "_bit"},        32'(resp_bit),   0);
        check({tag, "_unstable"},   32'(unstable),   0);
        check({tag, "_ones"},       32'(ones_count), 0);
    endtask

    // One full evaluation. pat[v] is what the modelled arbiter answers on
    // vote v. intrude_e (>=0) is the cycle at which a second start with
    // intrude_ch is attempted while busy. Called #1 after an edge in IDLE.
    task automatic run_eval(input string tag, input logic [CH_W-1:0] ch,
                            input logic [VOTES-1:0] pat, input int ack_delay,
                            input bit ack_with_start, input int intrude_e,
                            input logic [CH_W-1:0] intrude_ch);
        int clr_hi = 0, launch_hi = 0, shape_bad = 0, ch_bad = 0;
        int busy_bad = 0, early_valid = 0, hold_bad = 0;
        int exp_ones;
        logic exp_bit, exp_unst;

        exp_ones = $countones(pat);
        exp_bit  = (exp_ones > VOTES / 2);
        exp_unst = (exp_ones != 0) && (exp_ones != VOTES);

        puf_resp  = pat[0];
        start     = 1'b1;
        challenge = ch;
        tick();
        start     = 1'b0;
        challenge = CH_W'($urandom);
        check({tag, "_ones_cleared"}, 32'(ones_count), 0);

        for (int e = 0; e < LATENCY; e++) begin
            int ph;
            int v;
            ph = e % VOTE_LEN;
            v  = e / VOTE_LEN;
            if (puf_clr !== (ph < CLR_CYC)) shape_bad++;
            if (puf_launch !== (ph >= CLR_CYC)) shape_bad++;
            if (puf_clr === 1'b1) clr_hi++;
            if (puf_launch === 1'b1) launch_hi++;
            if (ch_out !== ch) ch_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (resp_valid !== 1'b0) early_valid++;
            puf_resp = pat[v];
            if (e == intrude_e) begin
                start     = 1'b1;
                challenge = intrude_ch;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;

        check({tag, "_valid_at_latency"}, 32'(resp_valid), 1);
        check({tag, "_ones_count"},       32'(ones_count), 32'(exp_ones));
        check({tag, "_resp_bit"},         32'(resp_bit),   32'(exp_bit));
        check({tag, "_unstable"},         32'(unstable),   32'(exp_unst));
        check({tag, "_busy_done"},        32'(busy),       1);
        check({tag, "_ch_out_done"},      32'(ch_out),     32'(ch));
        check({tag, "_clr_cycles"},       32'(clr_hi),     32'(VOTES * CLR_CYC));
        check({tag, "_launch_cycles"},    32'(launch_hi),  32'(VOTES * (SETTLE_CYC + 2)));
        check({tag, "_phase_shape"},      32'(shape_bad),  0);
        check({tag, "_ch_out_stable"},    32'(ch_bad),     0);
        check({tag, "_busy_run"},         32'(busy_bad),   0);
        check({tag, "_valid_early"},      32'(early_valid), 0);

        // Result must stay put while the ack is withheld; a start here is
        // ignored too.
        for (int i = 0; i < ack_delay; i++) begin
            start     = (i == ack_delay / 2);
            challenge = CH_W'($urandom);
            tick();
            if (resp_valid !== 1'b1 || resp_bit !== exp_bit || unstable !== exp_unst ||
                ones_count !== CNT_W'(exp_ones) || ch_out !== ch || busy !== 1'b1 ||
                puf_clr !== 1'b0 || puf_launch !== 1'b0)
                hold_bad++;
        end
        start = 1'b0;
        check({tag, "_hold_stable"}, 32'(hold_bad), 0);

        resp_ack  = 1'b1;
        start     = ack_with_start;
        challenge = CH_W'($urandom);
        tick();
        resp_ack = 1'b0;
        start    = 1'b0;
        check({tag, "_valid_after_ack"}, 32'(resp_valid), 0);
        check({tag, "_busy_after_ack"},  32'(busy),       0);
        check({tag, "_ch_out_idle"},     32'(ch_out),     32'(ch));
        tick();
        check({tag, "_still_idle"},      32'(busy),       0);
        check({tag, "_no_clr_idle"},     32'(puf_clr),    0);
    endtask

    initial begin
        int valid_seen;
        int busy_seen;

        rst_n     = 1'b0;
        start     = 1'b0;
        challenge = '0;
        resp_ack  = 1'b0;
        puf_resp  = 1'b0;
        #2;
        check_all_zero("reset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // All-ones arbiter with a second start attempted mid-run, ack held off.
        run_eval("all_ones", 8'hA5, 7'b1111111, 20, 1'b1, 60, 8'h3C);

        // Arbiter answers 1 only on votes 0, 2 and 4.
        run_eval("votes_024", 8'hA5, 7'b0010101, 0, 1'b0, -1, 8'h00);

        // Reset pulsed during SETTLE of vote 3.
        start     = 1'b1;
        challenge = 8'h5A;
        puf_resp  = 1'b1;
        tick();
        start = 1'b0;
        repeat (3 * VOTE_LEN + CLR_CYC + 1 + 6) tick();
        check("pre_reset_launch", 32'(puf_launch), 1);
        check("pre_reset_busy",   32'(busy),       1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        valid_seen = 0;
        busy_seen  = 0;
        for (int i = 0; i < LATENCY + 20; i++) begin
            tick();
            if (resp_valid !== 1'b0) valid_seen++;
            if (busy !== 1'b0) busy_seen++;
        end
        check("post_reset_no_valid", 32'(valid_seen), 0);
        check("post_reset_idle",     32'(busy_seen),  0);
        run_eval("after_reset", CH_W'($urandom), VOTES'($urandom), 3, 1'b0, -1, 8'h00);

        // Randomized evaluations.
        for (int r = 0; r < 5; r++) begin
            run_eval($sformatf("rand%0d", r), CH_W'($urandom), VOTES'($urandom),
                     int'($urandom_range(0, 6)), 1'($urandom),
                     int'($urandom_range(0, LATENCY - 1)), CH_W'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time bound so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/puf_challenge_sequencer.md
PUF_CHALLENGE_SEQUENCER -- requirements
Module: puf_challenge_sequencer

Interface
- REQ-001: Parameter CH_W, default 8: challenge width, matches the arbiter PUF CH bus.
- REQ-002: Parameter VOTES, default 7: evaluations per challenge; SHALL be odd and >= 1.
- REQ-003: Parameter CLR_CYC, default 4: cycles the arbiter reset is held per evaluation; SHALL be >= 1.
- REQ-004: Parameter SETTLE_CYC, default 16: cycles from launch to sample; SHALL be >= 3.
- REQ-005: Port clk, input, 1: single clock; all state updates on the rising edge.
- REQ-006: Port rst_n, input, 1: reset, asynchronous, active-low.
- REQ-007: Port start, input, 1: request an evaluation of the value on challenge.
- REQ-008: Port challenge, input, CH_W: challenge, sampled only when start is accepted.
- REQ-009: Port resp_ack, input, 1: consumer acknowledge of the result.
- REQ-010: Port puf_resp, input, 1: asynchronous arbiter output (RESP).
- REQ-011: Port ch_out, output, CH_W: drives the PUF CH bus.
- REQ-012: Port puf_launch, output, 1: drives the PUF mux_in race edge.
- REQ-013: Port puf_clr, output, 1: active-high arbiter/feed-forward flip-flop reset.
- REQ-014: Port busy, output, 1: high from the cycle after accept until return to IDLE.
- REQ-015: Port resp_valid, resp_bit, unstable, outputs, 1 each: result handshake, majority bit, disagreement flag.
- REQ-016: Port ones_count, output, clog2(VOTES+1): number of evaluations that sampled 1.

Function
- REQ-017: puf_resp SHALL pass through a 2-flop synchronizer; only the synchronized value is used.
- REQ-018: FSM states SHALL be IDLE, CLEAR, LAUNCH, SETTLE, SAMPLE, DONE.
- REQ-019: IDLE: start=1 SHALL latch challenge into ch_out, clear the vote index and ones_count, and go to CLEAR; start is ignored in every other state.
- REQ-020: CLEAR: puf_clr=1 and puf_launch=0 for exactly CLR_CYC cycles, then LAUNCH.
- REQ-021: LAUNCH: one cycle, puf_clr=0; puf_launch SHALL go to 1 here and stay 1 through SETTLE and SAMPLE.
- REQ-022: SETTLE: exactly SETTLE_CYC cycles, then SAMPLE.
- REQ-023: SAMPLE: one cycle; ones_count += synchronized puf_resp; if the vote index equals VOTES-1, go to DONE, else increment the index and go to CLEAR.
- REQ-024: puf_launch SHALL be 0 in IDLE, CLEAR and DONE; puf_clr SHALL be 0 in every state except CLEAR.
- REQ-025: ch_out SHALL stay constant from accept through DONE, and keep its last value in IDLE.
- REQ-026: DONE: resp_valid=1; resp_bit = (ones_count > VOTES/2); unstable = (ones_count != 0 and ones_count != VOTES). All are held stable until resp_ack=1.
- REQ-027: resp_ack=1 in DONE SHALL return to IDLE next cycle; resp_valid drops that cycle. resp_ack outside DONE is ignored.
- REQ-028: start and resp_ack high in the same DONE cycle: the ack is honoured and the start is ignored.
- REQ-029: Latency: start accepted at edge k gives resp_valid=1 at cycle k+1+VOTES*(CLR_CYC+SETTLE_CYC+2). With defaults this is k+155.
- REQ-030: ones_count SHALL NOT wrap; its width holds VOTES exactly.

Reset
- REQ-031: rst_n=0 SHALL immediately force state IDLE, the synchronizer flops, vote index, ones_count, ch_out, puf_launch, puf_clr, busy, resp_valid, resp_bit and unstable to 0.
- REQ-032: Reset mid-evaluation SHALL abort it with no resp_valid; after release the block waits in IDLE for a new start.

Verification
- REQ-033: Assert rst_n=0 mid-run -> all outputs 0 in the same cycle, busy=0.
- REQ-034: start with challenge=0xA5, puf_resp tied 1 -> ch_out=0xA5 throughout; resp_valid at k+155; resp_bit=1, ones_count=7, unstable=0.
- REQ-035: puf_resp model returns 1 only on votes 0,2,4 -> resp_bit=0, ones_count=3, unstable=1; puf_clr high for 4 cycles and puf_launch high for 18 cycles per vote.
- REQ-036: start with challenge=0x3C while busy -> ignored; ch_out stays 0xA5; no extra evaluation.
- REQ-037: rst_n pulsed low during SETTLE of vote 3 -> no resp_valid; a following start completes in 155 cycles with correct counts.
- REQ-038: resp_ack withheld 20 cycles -> resp_valid and result stay stable; then resp_ack and start together -> IDLE, start ignored, busy=0.
